log_taylor_npp: RTL
===================

// Module: log_taylor_npp
// PURPOSE
//   Iterative natural-log unit, inverse of the exp Taylor neuron: ln(x) = e*ln2 + ln(1+u) via truncated Taylor series.
//   One shared multiplier, coefficient ROM (+-1/k) and accumulator; same iDataValid/oDataRead/oDataValid handshake as the exp unit.
//   Sits in the configurable neuron datapath for log-domain / softmax normalisation.
// PARAMETERS
//   WIDTH    32  total data width; iData unsigned, oData two's complement
//   FRAC     24  fraction bits of iData and oData (fixed point WIDTH-FRAC . FRAC)
//   MAXTERM  8   highest series term k (2..15); 4-bit term counter
// PORTS
//   clk         in   1      clock, all flops rising edge
//   rst         in   1      reset, asynchronous, active-high
//   iData       in   WIDTH  x, unsigned fixed point, sampled when iDataValid=1
//   iDataValid  in   1      start; restarts any calculation in progress
//   oDataRead   in   1      early terminate: skip remaining terms, go to FINAL
//   oData       out  WIDTH  ln(x), signed fixed point, FRAC fraction bits
//   oDataValid  out  1      oData valid; held until next iDataValid
// BEHAVIOUR
//   Reset: state=IDLE, oData=0, oDataValid=0, all datapath regs 0. Reset mid-operation aborts silently.
//   States: IDLE -> NORM -> ITER -> FINAL -> DONE; DONE holds. iDataValid in ANY state: capture x, go NORM,
//     oDataValid drops same cycle (combinationally masked by iDataValid, registered low next edge).
//   NORM (1 cyc): leading-one detect, e = pos - FRAC (signed), m = x*2^-e in [1,2).
//     Fold: m >= 1.5 -> u = m/2 - 1 (negative, |u| <= 0.25), e = e+1; else u = m - 1 in [0,0.5).
//     sum = u (term k=1), pow = u, k = 2.
//   ITER: two cycles per term. Phase A: pow = pow*u (trunc to FRAC). Phase B: sum += pow*c_k,
//     c_k = (-1)^(k+1)/k from ROM (FRAC-bit magnitude, sign applied in accumulator); k++.
//     After phase B of k==MAXTERM -> FINAL. oDataRead during ITER: finish current phase B if in phase A
//     (fully add current term), then FINAL. oDataRead outside ITER ignored.
//   FINAL (1 cyc): oData = sat(sum + e*LN2), LN2 = round(ln2*2^FRAC); -> DONE, oDataValid=1 next edge.
//   Latency (no early read): iDataValid edge to oDataValid high = 2*MAXTERM+1 cycles.
//   Arithmetic: products full 2*WIDTH, truncated toward -inf to FRAC bits; accumulator WIDTH+2 bits;
//     output saturates to signed WIDTH range.
//   x == 0: NORM detects zero, skips ITER, FINAL drives oData = most-negative (1<<(WIDTH-1)), same latency path (3 cycles).
//   iDataValid and oDataRead same cycle: start wins, oDataRead ignored.
//   oData/oDataValid stable in DONE; no change until next iDataValid or reset.
// CONFIGURATION
//   `LOG_ERR_FLAG_EN defined: extra port oErr (out, 1): 1 with oDataValid when x==0 or output saturated;
//     reset 0, cleared on iDataValid.
//   Undefined: no oErr port; zero input and saturation still give the saturated oData, unflagged.
// TESTING (WIDTH=32, FRAC=24, MAXTERM=8; tolerance +-4096 LSB unless stated)
//   x=0x0100_0000 (1.0) -> oData=0x0000_0000 exactly, oDataValid at cycle 17 after start.
//   x=0x0200_0000 (2.0) -> oData=0x00B1_7218 +-2 LSB; x=0x0080_0000 (0.5) -> 0xFF4E_8DE8 +-2 LSB.
//   x=0x02B7_E151 (e) -> oData=0x0100_0000; x=0x0180_0000 (1.5, fold path) -> 0x0067_CC8F.
//   x=0x02B7_E151, oDataRead at cycle 5 -> oDataValid earlier than cycle 17, error < 2^-6.
//   x=0 -> oData=0x8000_0000 (oErr=1 if LOG_ERR_FLAG_EN); new iDataValid at cycle 6 of a run -> restart,
//     oDataValid=0 during restart, result of new x only; rst pulse mid-ITER -> all outputs 0.

Source files
------------

// File: rtl/log_taylor_npp.sv
// Iterative natural log: ln(x) = e*ln2 + ln(1+u), truncated Taylor series on one shared multiplier.
// Optional `LOG_ERR_FLAG_EN adds oErr, flagging zero input or a saturated result.
module log_taylor_npp #(
    parameter int WIDTH   = 32,
    parameter int FRAC    = 24,
    parameter int MAXTERM = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] iData,
    input  logic             iDataValid,
    input  logic             oDataRead,
    output logic [WIDTH-1:0] oData,
`ifdef LOG_ERR_FLAG_EN
    output logic             oErr,
`endif
    output logic             oDataValid
);
    localparam int AW = WIDTH + 2;
    localparam int PW = 2 * AW;
    localparam int PS = $clog2(WIDTH);
    localparam int EW = PS + 2;
    localparam int WW = AW + EW + 2;
    localparam logic signed [AW-1:0] ONE  = AW'(1) << FRAC;
    localparam logic signed [WW-1:0] LN2  = WW'(longint'(0.6931471805599453 * (2.0 ** FRAC)));
    localparam logic signed [WW-1:0] SMAX = WW'((longint'(1) << (WIDTH - 1)) - 1);
    localparam logic signed [WW-1:0] SMIN = ~SMAX;

    typedef enum logic [2:0] {IDLE, NORM, ITER_A, ITER_B, FINAL, DONE} state_t;

    state_t               state, nxt;
    logic [WIDTH-1:0]     x_reg;
    logic signed [EW-1:0] e_reg;
    logic signed [AW-1:0] u_reg, pow, sum;
    logic [3:0]           k;
    logic                 stop_req, out_vld, err_r;

    // Coefficient ROM: round(2^FRAC / k), sign applied when accumulating
    logic [FRAC-1:0] coef;
    always_comb begin
        coef = '0;
        for (int i = 2; i < 16; i++)
            if (k == 4'(i)) coef = FRAC'(((longint'(1) << (FRAC + 1)) / i + 1) >> 1);
    end

    logic                 x_zero, fold;
    logic [PS-1:0]        pos, shamt;
    logic [WIDTH-1:0]     norm;
    logic [FRAC:0]        m_fix;
    logic signed [EW-1:0] e_n;
    logic signed [AW-1:0] u_n;
    always_comb begin
        x_zero = (x_reg == '0);
        pos    = '0;
        for (int i = 0; i < WIDTH; i++)
            if (x_reg[i]) pos = PS'(i);
        shamt = PS'(WIDTH - 1) - pos;
        norm  = x_reg << shamt;
        m_fix = norm[WIDTH-1 -: FRAC+1];
        // m >= 1.5 is folded to m/2 so |u| stays small and the series converges faster
        fold  = m_fix[FRAC-1];
        e_n   = $signed(EW'(pos)) - EW'(FRAC) + (fold ? EW'(1) : EW'(0));
        u_n   = fold ? $signed(AW'(m_fix[FRAC:1])) - ONE : $signed(AW'(m_fix)) - ONE;
    end

    logic signed [PW-1:0] pow_w, u_w, c_w, prod_a, prod_b;
    logic signed [AW-1:0] pow_n, term, sum_n;
    always_comb begin
        pow_w  = pow;
        u_w    = u_reg;
        c_w    = $signed({{(PW-FRAC){1'b0}}, coef});
        prod_a = pow_w * u_w;
        prod_b = pow_w * c_w;
        pow_n  = AW'(prod_a >>> FRAC);
        term   = AW'(prod_b >>> FRAC);
        sum_n  = k[0] ? sum + term : sum - term;
    end

    logic signed [WW-1:0] sum_w, e_w, fin;
    logic                 sat;
    logic [WIDTH-1:0]     fin_q;
    always_comb begin
        sum_w = sum;
        e_w   = e_reg;
        fin   = sum_w + e_w * LN2;
        sat   = (fin > SMAX) || (fin < SMIN);
        if (x_zero)          fin_q = {1'b1, {(WIDTH-1){1'b0}}};
        else if (fin > SMAX) fin_q = SMAX[WIDTH-1:0];
        else if (fin < SMIN) fin_q = SMIN[WIDTH-1:0];
        else                 fin_q = fin[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            NORM:    nxt = x_zero ? FINAL : ITER_A;
            ITER_A:  nxt = ITER_B;
            ITER_B:  nxt = (k == 4'(MAXTERM) || stop_req || oDataRead) ? FINAL : ITER_A;
            FINAL:   nxt = DONE;
            default: nxt = state;
        endcase
        if (iDataValid) nxt = NORM;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg    <= '0;
            e_reg    <= '0;
            u_reg    <= '0;
            pow      <= '0;
            sum      <= '0;
            k        <= '0;
            stop_req <= 1'b0;
            out_vld  <= 1'b0;
            err_r    <= 1'b0;
            oData    <= '0;
        end else if (iDataValid) begin
            x_reg    <= iData;
            stop_req <= 1'b0;
            out_vld  <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            case (state)
                NORM: begin
                    e_reg <= e_n;
                    u_reg <= u_n;
                    pow   <= u_n;
                    sum   <= u_n;
                    k     <= 4'd2;
                end
                ITER_A: begin
                    pow <= pow_n;
                    if (oDataRead) stop_req <= 1'b1;
                end
                ITER_B: begin
                    sum <= sum_n;
                    k   <= k + 4'd1;
                end
                FINAL: begin
                    oData   <= fin_q;
                    out_vld <= 1'b1;
                    err_r   <= x_zero || sat;
                end
                default: ;
            endcase
        end
    end

    assign oDataValid = out_vld & ~iDataValid;
`ifdef LOG_ERR_FLAG_EN
    assign oErr = err_r;
`else
    logic unused_err;
    assign unused_err = err_r;
`endif
endmodule
